hc283_seq_adder: RTL and testbench
==================================

Name: hc283_seq_adder

Overview:
Multi-cycle, parametrised add/subtract unit that chains a SLICE-bit adder over WIDTH-bit operands, one slice per clock, through a registered ripple carry. It generalises the 4-bit combinational adder to arbitrary width, adds a subtract mode, status flags and a start/busy/done handshake. It sits in the CPU datapath as the wide ALU add path.

Parameters:
WIDTH, 16, total operand/result width; must be a positive multiple of SLICE.
SLICE, 4, bits added per clock cycle; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request an operation; sampled only when accepted (see Behaviour).
sub  input  1  0 = add, 1 = subtract; latched with operands.
cin  input  1  carry-in (add) / borrow-in (sub); latched with operands.
inA  input  WIDTH  operand A.
inB  input  WIDTH  operand B.
out  output  WIDTH  result.
cout  output  1  raw carry out of the MSB slice.
ovf  output  1  two's-complement signed overflow.
zero  output  1  high when out == 0.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Interface: single clock clk; rst asynchronous, active-high; all state is cleared immediately on rst assertion.
- Reset values: out = 0, cout = 0, ovf = 0, zero = 0, busy = 0, done = 0, state = IDLE.
- NS = WIDTH/SLICE slices.
- States: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE. On the accepting edge:
  - latch A = inA;
  - latch B' = inB when sub = 0, ~inB when sub = 1;
  - carry register = cin when sub = 0, ~cin when sub = 1;
  - slice index = 0; state -> RUN.
- start is ignored in RUN. No effect on any register; busy stays high.
- RUN, each edge: compute {c, s} = A[i] + B'[i] + carry, where i is the current slice.
  - Write s into out[i*SLICE +: SLICE] and c into the carry register.
  - For the top slice, also record the carry into the MSB for overflow.
  - Increment the index.
  - After slice NS-1 is written: state -> DONE; cout = final carry; ovf = carry-into-MSB XOR carry-out-of-MSB; zero = (full result == 0).
- Latency: start accepted at edge k; done = 1 after edge k+NS, for exactly one cycle.
- busy is high from edge k+1 through edge k+NS, and is low while done is high.
- DONE, next edge: start = 1 accepts a new operation (back-to-back, no IDLE gap); start = 0 returns to IDLE.
- Hold rules:
  - out, cout, ovf and zero hold their final values after done until the next accepted start.
  - Partial out bits update slice by slice during RUN; they are not valid until done.
  - zero, ovf and cout update only at completion.
- Subtract semantics: result = A - B - cin mod 2^WIDTH. cout = 1 means no borrow (raw carry, not inverted).
- Wrap-around: the result is modulo 2^WIDTH; the carry is exported only on cout.
- Reset mid-RUN: aborts the operation; no done pulse; all outputs return to reset values.
- Operand changes: inA, inB, sub and cin are don't-care except on the accepting edge.
- WIDTH == SLICE: NS = 1, so done follows the accepting edge by one cycle.

Test Plan:
1. Add, defaults: A=0x1234, B=0x4321, sub=0, cin=0 -> out=0x5555, cout=0, ovf=0, zero=0; busy high 4 cycles, done pulses once on the 4th edge after the accepting edge.
2. Carry wrap: A=0xFFFF, B=0x0001 -> out=0x0000, cout=1, zero=1, ovf=0. Then A=0x7FFF, B=0x0001 -> out=0x8000, cout=0, ovf=1.
3. Subtract: A=0x0005, B=0x0007, sub=1, cin=0 -> out=0xFFFE, cout=0, ovf=0. Then A=0x0007, B=0x0005 -> out=0x0002, cout=1. Then A=0x8000, B=0x0001 -> out=0x7FFF, ovf=1.
4. Busy protection: start 0x1111+0x1111, pulse start with 0xAAAA+0x5555 in cycle 2 of RUN -> out=0x2222; single done; second request lost.
5. Back-to-back: hold start high with new operands on the done cycle -> second operation begins without an IDLE cycle; second done exactly 5 edges after the first.
6. Reset mid-op: assert rst asynchronously (between edges) during slice 2 -> all outputs 0 immediately, no done. After release, 0x0001+0x0001 -> out=0x0002. Rerun case 1 with WIDTH=8, SLICE=1 (0x12+0x21 -> 0x33) and check 8-cycle latency.

Source files
------------

// File: rtl/hc283_seq_adder_if.sv
// Handshake and operand/result bundle for the slice-serial add/subtract unit.
interface hc283_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, cin, inA, inB,
        input  out, cout, ovf, zero, busy, done
    );

    modport slave (
        input  start, sub, cin, inA, inB,
        output out, cout, ovf, zero, busy, done
    );
endinterface

// File: rtl/hc283_seq_adder.sv
// Wide add/subtract built from one SLICE-bit adder reused per clock,
// with the carry rippled between slices through a register.
module hc283_seq_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic              clk,
    input logic              rst,
    hc283_seq_adder_if.slave bus
);
    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int SW = SLICE + 1;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [31:0]      off;
    logic [SLICE-1:0] a_sl, b_sl, s_sl;
    logic             c_sl, c_into_msb, last;

    always_comb begin
        off  = 32'(idx_q) * 32'(SLICE);
        a_sl = SLICE'(a_q >> off);
        b_sl = SLICE'(b_q >> off);
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + SW'(carry_q);
        // Sum bit is a^b^carry_in, so the carry into the top bit falls out of it.
        c_into_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1];
        last = (idx_q == IW'(NS - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.inA;
                    b_d     = bus.sub ? ~bus.inB : bus.inB;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                out_d   = (out_q & ~(MASK << off)) | (WIDTH'(s_sl) << off);
                carry_d = c_sl;
                idx_d   = idx_q + 1'b1;
                busy_d  = 1'b1;
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = c_sl;
                    ovf_d   = c_sl ^ c_into_msb;
                    zero_d  = (out_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_hc283_seq_adder.sv
// Directed plus random checks of the slice-serial adder in a 16/4 and an 8/1 configuration.
module tb_hc283_seq_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hc283_seq_adder_if #(.WIDTH(16)) a_if ();
    hc283_seq_adder_if #(.WIDTH(8))  b_if ();

    hc283_seq_adder #(.WIDTH(16), .SLICE(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    hc283_seq_adder #(.WIDTH(8),  .SLICE(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Reference: {ovf, zero, cout, out} from plain integer arithmetic.
    function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
        longint m, ua, ub, r, ro, sa, sb, sr;
        logic co, ov;
        m  = longint'(1) << w;
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        r  = s ? ua - ub - longint'(c) : ua + ub + longint'(c);
        co = s ? (r >= 0) : (r >= m);
        ro = ((r % m) + m) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = s ? sa - sb - longint'(c) : sa + sb + longint'(c);
        ov = (sr < -(m / 2)) || (sr >= m / 2);
        return {ov, (ro == 0), co, 16'(ro)};
    endfunction

    // {busy, done, ovf, zero, cout, out}
    function automatic logic [20:0] obs(input bit w8);
        if (w8) return {b_if.busy, b_if.done, b_if.ovf, b_if.zero, b_if.cout, 8'h00, b_if.out};
        return {a_if.busy, a_if.done, a_if.ovf, a_if.zero, a_if.cout, a_if.out};
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c);
        if (w8) begin
            b_if.start = st; b_if.inA = a[7:0]; b_if.inB = b[7:0]; b_if.sub = s; b_if.cin = c;
        end else begin
            a_if.start = st; a_if.inA = a; a_if.inB = b; a_if.sub = s; a_if.cin = c;
        end
    endtask

    task automatic drive_idle(input bit w8);
        drive(w8, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, input string tag);
        logic [18:0] e;
        logic [20:0] o;
        int lat, ns;
        ns = w8 ? 8 : 4;
        e  = model(w8 ? 8 : 16, a, b, s, c);
        @(negedge clk);
        drive(w8, 1'b1, a, b, s, c);
        @(negedge clk);
        drive_idle(w8);
        lat = 0;
        while (!obs(w8)[19] && lat < 50) begin
            chk({tag, "_busy"}, 32'(obs(w8)[20]), 32'd1);
            @(negedge clk);
            lat++;
        end
        o = obs(w8);
        chk({tag, "_lat"}, lat, ns);
        chk({tag, "_busy_done"}, 32'(o[20]), 32'd0);
        chk({tag, "_res"}, 32'(o[18:0]), 32'(e));
        @(negedge clk);
        o = obs(w8);
        chk({tag, "_pulse"}, 32'(o[19]), 32'd0);
        chk({tag, "_hold"}, 32'(o[18:0]), 32'(e));
    endtask

    initial begin
        int lat, nd;
        logic [18:0] e;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_a", 32'(obs(0)), 32'd0);
        chk("reset_b", 32'(obs(1)), 32'd0);
        rst = 1'b0;

        do_op(0, 16'h1234, 16'h4321, 0, 0, "add");
        do_op(0, 16'hFFFF, 16'h0001, 0, 0, "wrap");
        do_op(0, 16'h7FFF, 16'h0001, 0, 0, "povf");
        do_op(0, 16'h0005, 16'h0007, 1, 0, "sub_neg");
        do_op(0, 16'h0007, 16'h0005, 1, 0, "sub_pos");
        do_op(0, 16'h8000, 16'h0001, 1, 0, "sub_ovf");
        do_op(0, 16'h0000, 16'h0000, 1, 1, "sub_bin");

        // start while running must be ignored
        @(negedge clk); drive(0, 1, 16'h1111, 16'h1111, 0, 0);
        @(negedge clk); drive_idle(0);
        @(negedge clk); drive(0, 1, 16'hAAAA, 16'h5555, 0, 0);
        @(negedge clk); drive_idle(0);
        chk("prot_busy", 32'(a_if.busy), 32'd1);
        lat = 2;
        while (!a_if.done && lat < 50) begin @(negedge clk); lat++; end
        chk("prot_lat", lat, 4);
        chk("prot_out", 32'(a_if.out), 32'h2222);
        nd = 0;
        repeat (8) begin @(negedge clk); if (a_if.done) nd++; end
        chk("prot_single_done", nd, 0);

        // back-to-back: new start on the done cycle
        @(negedge clk); drive(0, 1, 16'h1234, 16'h4321, 0, 0);
        @(negedge clk); drive_idle(0);
        lat = 0;
        while (!a_if.done && lat < 50) begin @(negedge clk); lat++; end
        chk("b2b_first", 32'(a_if.out), 32'h5555);
        drive(0, 1, 16'h0F0F, 16'h0101, 1, 0);
        @(negedge clk); drive_idle(0);
        lat = 1;
        chk("b2b_no_idle", 32'(a_if.busy), 32'd1);
        while (!a_if.done && lat < 50) begin @(negedge clk); lat++; end
        chk("b2b_gap", lat, 5);
        e = model(16, 16'h0F0F, 16'h0101, 1, 0);
        chk("b2b_second", 32'(obs(0)[18:0]), 32'(e));

        // asynchronous reset in the middle of a run
        @(negedge clk); drive(0, 1, 16'h1234, 16'h4321, 0, 0);
        @(negedge clk); drive_idle(0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(a_if.busy), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_async", 32'(obs(0)), 32'd0);
        @(negedge clk); rst = 1'b0;
        nd = 0;
        repeat (8) begin @(negedge clk); if (a_if.done) nd++; end
        chk("rst_no_done", nd, 0);
        do_op(0, 16'h0001, 16'h0001, 0, 0, "post_rst");

        do_op(1, 16'h0012, 16'h0021, 0, 0, "w8_add");
        do_op(1, 16'h0080, 16'h0001, 1, 0, "w8_sub_ovf");

        for (int i = 0; i < 24; i++)
            do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
